// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared UART definitions: default bit timing, data width,
//               the fixed "Hello, World\r\n" message ROM and the receiver
//               FSM state encoding. Used by both the RX monitor and the
//               TX wrapper so both ends agree on the message.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 27 MHz / 115200 baud
  localparam int UART_D = 234;
  localparam int UART_L = 8;

  localparam int MSG_LEN = 14;
  localparam logic [3:0] MSG_LAST_IDX = 4'(MSG_LEN - 1);
  localparam logic [7:0] MSG_FIRST = 8'h48;

  // Byte i of the message lives at bits [8*i +: 8]
  localparam logic [MSG_LEN*8-1:0] MSG_ROM = {
    8'h0A, 8'h0D, 8'h64, 8'h6C, 8'h72, 8'h6F, 8'h57,
    8'h20, 8'h2C, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
  };

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // ROM lookup; out-of-range indices return 0x00. The loop only uses
  // constant part-selects so no index can run past the ROM.
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == 4'(i)) b = MSG_ROM[8*i +: 8];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1-style UART receiver. Two-flop synchronizer on the serial
//               input, mid-bit sampling FSM, LSB-first shifter and stop-bit
//               check. Returns to idle at the middle of the stop bit so
//               back-to-back frames without an idle gap are received.
// Ports       : i_clk       - system clock
//               i_rst       - asynchronous active-high reset
//               i_rxd       - serial input, idle high, asynchronous
//               o_data      - last correctly framed byte
//               o_valid     - one-cycle pulse, o_data updated this cycle
//               o_frame_err - one-cycle pulse, stop bit sampled low
//               o_busy      - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int D = UART_D,
  parameter int L = UART_L
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rxd,
  output logic [L-1:0] o_data,
  output logic         o_valid,
  output logic         o_frame_err,
  output logic         o_busy
);

  localparam int CW = $clog2(D);
  localparam int BW = $clog2(L + 1);
  localparam logic [CW-1:0] C_HALF = CW'(D / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(D - 1);
  localparam logic [BW-1:0] C_LAST = BW'(L - 1);

  logic          rx_meta_q, rx_sync_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [L-1:0]  shift_q, shift_d;
  logic [L-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          rxs;

  assign rxs = rx_sync_q;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rxs) state_d = RX_START;
      end

      // Re-check the line half a bit in; a high here was a glitch.
      RX_START: begin
        if (clk_cnt_q == C_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Counter was aligned to mid start bit, so each full period lands
      // on the middle of the next data bit.
      RX_DATA: begin
        if (clk_cnt_q == C_FULL) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[L-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == C_LAST) state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (clk_cnt_q == C_FULL) begin
          clk_cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Held-low line: wait for it to release so only one error is reported.
      RX_BREAK: begin
        clk_cnt_d = '0;
        if (rxs) state_d = RX_IDLE;
      end

      default: begin
        state_d   = RX_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= i_rxd;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_monitor
// Description : UART receive path plus message checker. Recovers bytes with
//               uart_rx and tracks them against the fixed 14-byte
//               "Hello, World\r\n" message, pulsing o_match on a complete
//               in-order message and o_mismatch on a wrong byte or a
//               framing error part-way through a message.
// Ports       : i_clk       - system clock
//               i_rst       - asynchronous active-high reset
//               i_rxd       - serial input, idle high, asynchronous
//               o_data      - last correctly framed byte
//               o_valid     - one-cycle pulse, o_data updated this cycle
//               o_frame_err - one-cycle pulse, stop bit sampled low
//               o_busy      - high whenever the receiver is not idle
//               o_match     - one-cycle pulse, full message received
//               o_mismatch  - one-cycle pulse, message broken
//               o_msg_cnt   - number of o_match pulses, wraps at 255
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int D = UART_D,
  parameter int L = UART_L
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rxd,
  output logic [L-1:0] o_data,
  output logic         o_valid,
  output logic         o_frame_err,
  output logic         o_busy,
  output logic         o_match,
  output logic         o_mismatch,
  output logic [7:0]   o_msg_cnt
);

  logic [L-1:0] rx_data;
  logic         rx_valid;
  logic         rx_frame_err;
  logic [7:0]   rx_byte;

  logic [3:0]   idx_q, idx_d;
  logic         match_q, match_d;
  logic         mismatch_q, mismatch_d;
  logic [7:0]   msg_cnt_q, msg_cnt_d;

  uart_rx #(
    .D (D),
    .L (L)
  ) u_uart_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rxd       (i_rxd),
    .o_data      (rx_data),
    .o_valid     (rx_valid),
    .o_frame_err (rx_frame_err),
    .o_busy      (o_busy)
  );

  // The message is byte oriented; compare on an 8-bit view of the data.
  assign rx_byte = 8'(rx_data);

  always_comb begin
    idx_d      = idx_q;
    msg_cnt_d  = msg_cnt_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;

    if (rx_valid) begin
      if (rx_byte == msg_byte(idx_q)) begin
        if (idx_q == MSG_LAST_IDX) begin
          match_d   = 1'b1;
          msg_cnt_d = msg_cnt_q + 8'd1;
          idx_d     = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        mismatch_d = 1'b1;
        // A stray 'H' is treated as the start of a fresh message.
        idx_d      = (rx_byte == MSG_FIRST) ? 4'd1 : 4'd0;
      end
    end else if (rx_frame_err && (idx_q != 4'd0)) begin
      mismatch_d = 1'b1;
      idx_d      = 4'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q      <= 4'd0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      msg_cnt_q  <= 8'd0;
    end else begin
      idx_q      <= idx_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      msg_cnt_q  <= msg_cnt_d;
    end
  end

  assign o_data      = rx_data;
  assign o_valid     = rx_valid;
  assign o_frame_err = rx_frame_err;
  assign o_match     = match_q;
  assign o_mismatch  = mismatch_q;
  assign o_msg_cnt   = msg_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_monitor
// Description : Self-checking bench for uart_rx_monitor at 16 clocks/bit.
//               Table of single frames plus directed sequences: full
//               message, resync on 'H', framing error with held-low line,
//               start-bit glitch and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_monitor;

  localparam int D = 16;

  logic       i_clk;
  logic       i_rst;
  logic       i_rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
  logic       o_match;
  logic       o_mismatch;
  logic [7:0] o_msg_cnt;

  uart_rx_monitor #(
    .D (D),
    .L (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy),
    .o_match     (o_match),
    .o_mismatch  (o_mismatch),
    .o_msg_cnt   (o_msg_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                           8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

  int n_cmp  = 0;
  int n_fail = 0;

  // Event counters maintained by the monitor
  int n_valid = 0, n_fe = 0, n_match = 0, n_mm = 0;
  int mm_at = 0;
  int viol = 0;
  logic saw_busy = 1'b0;
  logic prev_valid = 1'b0, prev_fe = 1'b0;
  logic [7:0] rx_q [$];

  int v0, f0, m0, mm0;

  always @(negedge i_clk) begin
    if (o_valid) begin
      n_valid++;
      rx_q.push_back(o_data);
    end
    if (o_frame_err) n_fe++;
    if (o_match) n_match++;
    if (o_mismatch) begin
      n_mm++;
      mm_at = n_valid;
    end
    if (o_busy) saw_busy = 1'b1;
    if (o_valid && o_frame_err) viol++;
    if (o_match && o_mismatch) viol++;
    if (o_match && !prev_valid) viol++;
    if (o_mismatch && !(prev_valid || prev_fe)) viol++;
    prev_valid = o_valid;
    prev_fe    = o_frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    i_rxd = v;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, D);
    for (int i = 0; i < 8; i++) drive_bit(b[i], D);
    drive_bit(stop, D);
  endtask

  task automatic send_msg_from(input int first);
    for (int i = first; i < 14; i++) send_frame(msg[i], 1'b1);
  endtask

  task automatic do_reset();
    i_rxd = 1'b1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic snap();
    v0  = n_valid;
    f0  = n_fe;
    m0  = n_match;
    mm0 = n_mm;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_valid;
    int         exp_fe;
    int         exp_mm;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // byte, stop, valid, frame_err, mismatch, o_data afterwards
    vecs[0] = '{8'h48, 1'b1, 1, 0, 0, 8'h48};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 1, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 1, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, 1, 0, 1, 8'hA5};
    vecs[4] = '{8'h3C, 1'b0, 0, 1, 0, 8'hA5};
    vecs[5] = '{8'h01, 1'b1, 1, 0, 1, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 1, 0, 1, 8'h80};

    i_rxd = 1'b1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data",      32'(o_data), 32'h00);
    check("rst_valid",     32'(o_valid), 32'h0);
    check("rst_frame_err", 32'(o_frame_err), 32'h0);
    check("rst_busy",      32'(o_busy), 32'h0);
    check("rst_match",     32'(o_match), 32'h0);
    check("rst_mismatch",  32'(o_mismatch), 32'h0);
    check("rst_msg_cnt",   32'(o_msg_cnt), 32'h0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    // ---- single-frame table ----
    for (int k = 0; k < 7; k++) begin
      snap();
      send_frame(vecs[k].b, vecs[k].stop);
      drive_bit(1'b1, D);
      check($sformatf("vec%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_fe", k),    32'(n_fe - f0),    32'(vecs[k].exp_fe));
      check($sformatf("vec%0d_mm", k),    32'(n_mm - mm0),   32'(vecs[k].exp_mm));
      check($sformatf("vec%0d_data", k),  32'(o_data),       32'(vecs[k].exp_data));
      check($sformatf("vec%0d_busy", k),  32'(o_busy),       32'h0);
    end

    // ---- full message, back to back ----
    do_reset();
    rx_q.delete();
    snap();
    send_msg_from(0);
    drive_bit(1'b1, D);
    check("msg_valid_cnt", 32'(n_valid - v0), 32'd14);
    for (int i = 0; i < 14; i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hXX;
      check($sformatf("msg_byte%0d", i), 32'(got), 32'(msg[i]));
    end
    check("msg_match",    32'(n_match - m0), 32'd1);
    check("msg_mismatch", 32'(n_mm - mm0),   32'd0);
    check("msg_cnt",      32'(o_msg_cnt),    32'd1);

    // ---- "Hel" + 'H' + "ello, World\r\n": resync on H ----
    do_reset();
    snap();
    send_frame(8'h48, 1'b1);
    send_frame(8'h65, 1'b1);
    send_frame(8'h6C, 1'b1);
    send_frame(8'h48, 1'b1);
    send_msg_from(1);
    drive_bit(1'b1, D);
    check("resync_mismatch", 32'(n_mm - mm0),   32'd1);
    check("resync_mm_pos",   32'(mm_at - v0),   32'd4);
    check("resync_match",    32'(n_match - m0), 32'd1);
    check("resync_msg_cnt",  32'(o_msg_cnt),    32'd1);

    // ---- reset during DATA of the 2nd message byte ----
    send_frame(8'h48, 1'b1);
    drive_bit(1'b0, D);
    drive_bit(1'b1, D);
    drive_bit(1'b0, D);
    drive_bit(1'b1, D / 2);
    check("pre_rst_busy", 32'(o_busy), 32'h1);
    i_rst = 1'b1;
    #1;
    check("midrst_busy",    32'(o_busy), 32'h0);
    check("midrst_data",    32'(o_data), 32'h00);
    check("midrst_msg_cnt", 32'(o_msg_cnt), 32'h00);
    @(posedge i_clk);
    #1;
    check("midrst_outs", 32'({o_valid, o_frame_err, o_match, o_mismatch, o_busy}), 32'h0);
    i_rxd = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_bit(1'b1, D);
    snap();
    send_msg_from(0);
    drive_bit(1'b1, D);
    check("postrst_match",    32'(n_match - m0), 32'd1);
    check("postrst_mismatch", 32'(n_mm - mm0),   32'd0);
    check("postrst_msg_cnt",  32'(o_msg_cnt),    32'd1);

    // ---- framing error with the line held low ----
    do_reset();
    snap();
    send_frame(8'h41, 1'b0);
    drive_bit(1'b0, 5 * D);
    drive_bit(1'b1, 2 * D);
    check("break_fe",    32'(n_fe - f0),    32'd1);
    check("break_valid", 32'(n_valid - v0), 32'd0);
    check("break_mm",    32'(n_mm - mm0),   32'd0);
    check("break_busy",  32'(o_busy),       32'h0);
    snap();
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1, D);
    check("after_break_valid", 32'(n_valid - v0), 32'd1);
    check("after_break_data",  32'(o_data),       32'h55);

    // framing error part-way through a message
    do_reset();
    send_frame(8'h48, 1'b1);
    send_frame(8'h65, 1'b1);
    snap();
    send_frame(8'h41, 1'b0);
    drive_bit(1'b1, 2 * D);
    check("midmsg_fe", 32'(n_fe - f0),  32'd1);
    check("midmsg_mm", 32'(n_mm - mm0), 32'd1);

    // ---- short low glitch on an idle line ----
    do_reset();
    snap();
    saw_busy = 1'b0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * D);
    check("glitch_valid",    32'(n_valid - v0), 32'd0);
    check("glitch_fe",       32'(n_fe - f0),    32'd0);
    check("glitch_saw_busy", 32'(saw_busy),     32'h1);
    check("glitch_busy",     32'(o_busy),       32'h0);

    check("pulse_rules", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
UART receive path paired with the existing "Hello, World\r\n" transmitter, for loopback and board bring-up. Recovers 8N1 bytes from i_rxd with mid-bit sampling and frame checking. Compares the byte stream against the fixed 14-byte message and reports whole-message matches and mismatches. Sits at chip top, fed directly by the RX pin or by the TX wrapper's o_txd in loopback.

Parameters:
D, 234, clock cycles per bit (27 MHz / 115200); must be >= 4
L, 8, data bits per frame, LSB first

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_rxd  in  1  serial input, idle high, asynchronous to i_clk
o_data  out  8  last correctly framed byte
o_valid  out  1  one-cycle pulse; o_data updated this cycle
o_frame_err  out  1  one-cycle pulse; stop bit sampled low
o_busy  out  1  high whenever FSM not in IDLE
o_match  out  1  one-cycle pulse; full message received in order
o_mismatch  out  1  one-cycle pulse; wrong byte or frame error mid-message
o_msg_cnt  out  8  count of o_match pulses, wraps 255 -> 0

Behaviour:
- Reset: o_data=0x00, o_valid=0, o_frame_err=0, o_busy=0, o_match=0, o_mismatch=0, o_msg_cnt=0, sync flops=1, FSM=IDLE, bit/clock counters=0, message index=0.
- i_rxd passes a 2-flop synchronizer; all decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs==0 -> START, clock counter=0.
- START: at counter==D/2-1 (integer divide), sample rxs. If 0 -> DATA with counters cleared. If 1 (glitch) -> IDLE with no output.
- DATA: sample rxs at each counter==D-1, shift in LSB first. After the L-th sample -> STOP.
- STOP: sample at counter==D-1 (mid stop bit). If rxs==1: o_data<=byte, o_valid pulse, -> IDLE. If rxs==0: o_frame_err pulse, o_data unchanged, -> BREAK.
- BREAK: wait for rxs==1, then -> IDLE. A held-low line produces exactly one o_frame_err.
- Returning at mid stop bit lets back-to-back frames, with no idle gap, be received.
- Checker: 4-bit index idx into message ROM 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 0D 0A.
- On o_valid, if byte==ROM[idx]:
  - idx==13: o_match pulse the following cycle, o_msg_cnt+1, idx=0.
  - otherwise: idx+1.
- On o_valid, if byte!=ROM[idx]:
  - o_mismatch pulse the following cycle.
  - idx=1 if byte==0x48, else idx=0, so the checker resyncs on 'H'.
- On o_frame_err with idx!=0: o_mismatch pulse, idx=0. With idx==0: no o_mismatch.
- Latency: o_valid rises 2 sync cycles + ~(L+1.5)*D cycles after the start-bit falling edge. o_match/o_mismatch lag o_valid by exactly 1 cycle.
- o_valid and o_frame_err are mutually exclusive. o_match and o_mismatch are mutually exclusive.
- Reset mid-frame: everything returns to reset values immediately, partial byte discarded, idx=0.

Decomposition:
- Shared package uart_pkg: UART_D default, UART_L default, MSG_LEN=14, message ROM constant, FSM state encoding.
- One sub-module uart_rx (synchronizer + FSM + shifter; outputs data/valid/frame_err/busy). The top instantiates it and adds the message checker and counter.
- The transmitter wrapper reuses uart_pkg for its message ROM.

Test Plan:
- D=16. Drive frame 0x48 at 16 clk/bit -> single o_valid with o_data=0x48, o_frame_err=0, o_busy low after mid stop bit.
- Loop back the TX wrapper (D=16) into i_rxd -> 14 o_valid pulses carrying the exact message, one o_match, o_msg_cnt=1, no o_mismatch.
- Send "Hel" then 0x48 then "ello, World\r\n" -> one o_mismatch at the 4th byte, then o_match, o_msg_cnt=1.
- Send 0x41 with stop bit forced low, then hold line low 5 bit times -> exactly one o_frame_err, no o_valid. Line high then a 0x55 frame -> o_valid with 0x55.
- Low glitch of 4 cycles (< D/2) on idle line -> no o_valid, no o_frame_err, FSM back in IDLE.
- Assert i_rst during DATA of 2nd message byte -> all outputs 0 next edge. Full message afterwards -> o_match, o_msg_cnt=1.
